// File: rtl/relu_max_pool_2d_if.sv
// relu_max_pool_2d_if: pixel stream bundle between convolution trees and the pooling stage
interface relu_max_pool_2d_if #(
    parameter int NUM_TREES = 2
);
    logic                     pixel_valid_in;
    logic [32*NUM_TREES-1:0]  pixel_in;
    logic [8*NUM_TREES-1:0]   pixel_out;
    logic                     pixel_valid_out;
    modport master (output pixel_valid_in, pixel_in, input pixel_out, pixel_valid_out);
    modport slave (input pixel_valid_in, pixel_in, output pixel_out, pixel_valid_out);
endinterface

// File: rtl/relu_max_pool_2d.sv
// relu_max_pool_2d: quantizing 2x2 max-pool over NUM_TREES raster streams, POOL_RELU_EN selects unsigned ReLU mode
module relu_max_pool_2d #(
    parameter int NUM_TREES = 2,
    parameter int ROW_WIDTH = 4,
    parameter int SHIFT     = 0
) (
    input logic               clock,
    input logic               reset,
    relu_max_pool_2d_if.slave bus
);
    localparam int CW = ROW_WIDTH > 2 ? $clog2(ROW_WIDTH) : 1;
    localparam int HW = ROW_WIDTH / 2;
    localparam int IW = HW > 1 ? $clog2(HW) : 1;

    function automatic logic [7:0] quant(input logic signed [31:0] x);
        logic signed [31:0] s;
`ifdef POOL_RELU_EN
        s = x < 0 ? '0 : x;
        s = s >>> SHIFT;
        return s > 255 ? 8'd255 : s[7:0];
`else
        s = x >>> SHIFT;
        return s > 127 ? 8'h7f : s < -128 ? 8'h80 : s[7:0];
`endif
    endfunction

    function automatic logic [7:0] vmax(input logic [7:0] a, input logic [7:0] b);
`ifdef POOL_RELU_EN
        return a > b ? a : b;
`else
        return $signed(a) > $signed(b) ? a : b;
`endif
    endfunction

    logic [CW-1:0]           col_q, col_d;
    logic                    row_q, row_d;
    logic                    a_valid_q, a_odd_q, a_row_q;
    logic [IW-1:0]           a_idx_q;
    logic [7:0]              a_pix_q [NUM_TREES];
    logic [7:0]              even_q [NUM_TREES];
    logic                    b_valid_q, b_row_q;
    logic [IW-1:0]           b_idx_q;
    logic [7:0]              b_max_q [NUM_TREES];
    logic [7:0]              lbuf_q [NUM_TREES][HW];
    logic [8*NUM_TREES-1:0]  pixel_out_q;
    logic                    pixel_valid_out_q;

    // raster position advances only on accepted pixels, wrapping at the row end
    always_comb begin
        col_d = !bus.pixel_valid_in ? col_q : col_q == CW'(ROW_WIDTH - 1) ? '0 : col_q + 1'b1;
        row_d = bus.pixel_valid_in && col_q == CW'(ROW_WIDTH - 1) ? ~row_q : row_q;
    end

    // position and pipeline qualifiers; a window completes only on an odd column
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q             <= '0;
            row_q             <= 1'b0;
            a_valid_q         <= 1'b0;
            b_valid_q         <= 1'b0;
            pixel_valid_out_q <= 1'b0;
        end else begin
            col_q             <= col_d;
            row_q             <= row_d;
            a_valid_q         <= bus.pixel_valid_in;
            b_valid_q         <= a_valid_q & a_odd_q;
            pixel_valid_out_q <= b_valid_q & b_row_q;
        end
    end

    // datapath: quantize, pair columns into a horizontal max, park even rows in the line buffer
    always_ff @(posedge clock) begin
        if (bus.pixel_valid_in) begin
            a_odd_q <= col_q[0];
            a_row_q <= row_q;
            a_idx_q <= IW'(col_q >> 1);
            for (int k = 0; k < NUM_TREES; k++) a_pix_q[k] <= quant(bus.pixel_in[32*k +: 32]);
        end
        if (a_valid_q && !a_odd_q)
            for (int k = 0; k < NUM_TREES; k++) even_q[k] <= a_pix_q[k];
        if (a_valid_q && a_odd_q) begin
            b_row_q <= a_row_q;
            b_idx_q <= a_idx_q;
            for (int k = 0; k < NUM_TREES; k++) b_max_q[k] <= vmax(even_q[k], a_pix_q[k]);
        end
        if (b_valid_q && !b_row_q)
            for (int k = 0; k < NUM_TREES; k++) lbuf_q[k][b_idx_q] <= b_max_q[k];
    end

    // pooled result combines the odd-row horizontal max with the buffered even-row max
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_out_q <= '0;
        end else if (b_valid_q && b_row_q) begin
            for (int k = 0; k < NUM_TREES; k++) pixel_out_q[8*k +: 8] <= vmax(b_max_q[k], lbuf_q[k][b_idx_q]);
        end
    end

    assign bus.pixel_out       = pixel_out_q;
    assign bus.pixel_valid_out = pixel_valid_out_q;
endmodule

// File: tb/tb_relu_max_pool_2d.sv
// tb_relu_max_pool_2d: directed frames with hand-computed pooled values and strobe timing
module tb_relu_max_pool_2d;
`ifdef POOL_RELU_EN
    localparam logic [7:0] A0 = 8'd138, A1 = 8'd150, N44 = 8'd0, N1K = 8'd0, BIG = 8'd255, C0 = 8'd0, C1 = 8'd50;
`else
    localparam logic [7:0] A0 = 8'd127, A1 = 8'd127, N44 = 8'hEA, N1K = 8'h80, BIG = 8'h7F, C0 = 8'hFF, C1 = 8'h32;
`endif
    logic clock = 1'b0;
    logic reset = 1'b0;
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int last_cyc;
    int f0 [8];
    int f1 [8];
    logic [15:0] got_v [$];
    int got_c [$];
    logic [15:0] exp_v [$];
    int exp_c [$];

    relu_max_pool_2d_if #(.NUM_TREES(2)) bus ();
    relu_max_pool_2d #(.NUM_TREES(2), .ROW_WIDTH(4), .SHIFT(1)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock)
        if (bus.pixel_valid_out) begin
            got_v.push_back(bus.pixel_out);
            got_c.push_back(cyc);
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic feed(input int a, input int b, input int gap);
        bus.pixel_valid_in = 1'b1;
        bus.pixel_in = {b, a};
        @(negedge clock);
        last_cyc = cyc;
        bus.pixel_valid_in = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic frame(input int gap, input logic [15:0] w0, input logic [15:0] w1);
        for (int i = 0; i < 8; i++) begin
            feed(f0[i], f1[i], gap);
            if (i == 5) begin exp_v.push_back(w0); exp_c.push_back(last_cyc + 2); end
            if (i == 7) begin exp_v.push_back(w1); exp_c.push_back(last_cyc + 2); end
        end
    endtask

    task automatic verify(input string tag);
        repeat (4) @(negedge clock);
        check($sformatf("%s count", tag), got_v.size(), exp_v.size());
        for (int i = 0; i < exp_v.size() && i < got_v.size(); i++) begin
            check($sformatf("%s val%0d", tag, i), got_v[i], exp_v[i]);
            check($sformatf("%s cyc%0d", tag, i), got_c[i], exp_c[i]);
        end
        got_v.delete(); got_c.delete(); exp_v.delete(); exp_c.delete();
    endtask

    initial begin
        bus.pixel_valid_in = 1'b0;
        bus.pixel_in = '0;
        repeat (3) @(negedge clock);
        check("reset out", bus.pixel_out, 0);
        check("reset valid", bus.pixel_valid_out, 0);
        reset = 1'b1;
        @(negedge clock);
        check("post reset out", bus.pixel_out, 0);
        f0 = '{252, 276, 10, 5, 1, 2, 300, -44};
        f1 = '{-44, -44, -44, -44, -44, -44, -44, -44};
        frame(0, {N44, A0}, {N44, A1});
        verify("gapless");
        frame(1, {N44, A0}, {N44, A1});
        verify("gapped");
        f1[6] = 1000;
        frame(0, {N44, A0}, {BIG, A1});
        verify("saturate");
        f1 = '{-1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000};
        frame(0, {N1K, A0}, {N1K, A1});
        verify("neg sat");
        f0 = '{-6, -20, 100, 40, -2, -30, 7, 8};
        f1 = '{-44, -44, -44, -44, -44, -44, -44, -44};
        frame(0, {N44, C0}, {N44, C1});
        verify("mixed");
        f0 = '{252, 276, 10, 5, 1, 2, 300, -44};
        for (int i = 0; i < 7; i++) feed(f0[i], f1[i], 0);
        reset = 1'b0;
        #1;
        check("midreset out", bus.pixel_out, 0);
        check("midreset valid", bus.pixel_valid_out, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("no stale strobe", got_v.size(), 0);
        check("after reset valid", bus.pixel_valid_out, 0);
        frame(0, {N44, A0}, {N44, A1});
        verify("restart");
        frame(0, {N44, A0}, {N44, A1});
        f0 = '{-6, -20, 100, 40, -2, -30, 7, 8};
        frame(0, {N44, C0}, {N44, C1});
        verify("four rows");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
